mips_lite_multicycle: RTL

Parametrised multicycle MIPS-lite core. It replaces the single-cycle datapath and its built-in memories with a five-state FSM that uses one shared external word-memory port with a req/ready handshake, so the memory can insert wait states. It adds `addi`, `j`, `halt`, illegal-instruction trapping, a retired-instruction counter and a debug register read port. It is the top-level CPU instance under a memory model or testbench.

---
 rtl/mips_lite_multicycle.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mips_lite_multicycle.sv
// Multicycle MIPS-lite core: FETCH/DECODE/EXEC/MEM/WB FSM sharing one req/ready word-memory port.
// 3-5 cycles per instruction plus one per memory wait cycle; FETCH/MEM hold their request until mem_ready.
module mips_lite_multicycle #(
    parameter int          ADDR_W   = 8,
    parameter logic [27:0] RESET_PC = 28'h0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic              o_trap,
    output logic [31:0]       o_instret,
    input  logic [4:0]        i_dbg_sel,
    output logic [31:0]       o_dbg_data
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir, r_a, r_b, r_imm, r_alu, r_mdr, r_instret;
    logic              r_trap;
    logic [31:0]       r_regs [32];

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_wb_dst;
    logic              w_fire, w_legal;
    logic [31:0]       w_alu_res, w_wb_dat;
    logic [ADDR_W-1:0] w_br_target, w_j_target;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];

    // Request is gated by reset so a ready arriving alongside reset never completes a transfer.
    assign o_mem_req   = !i_reset && (r_state == S_FETCH || r_state == S_MEM);
    assign w_fire      = o_mem_req && i_mem_ready;
    assign o_mem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign o_mem_addr  = (r_state == S_MEM) ? {r_alu[ADDR_W-1:2], 2'b00} : r_pc;
    assign o_mem_wdata = r_b;

    assign o_pc       = r_pc;
    assign o_halted   = (r_state == S_HALT);
    assign o_trap     = r_trap;
    assign o_instret  = r_instret;
    assign o_dbg_data = (i_dbg_sel == 5'd0) ? 32'd0 : r_regs[i_dbg_sel];

    // r_pc already holds PC+4 when EXEC resolves a branch.
    assign w_br_target = r_pc + {r_imm[ADDR_W-3:0], 2'b00};
    assign w_j_target  = {r_ir[ADDR_W-3:0], 2'b00};
    assign w_wb_dst    = (w_op == OP_R) ? w_rd : w_rt;
    assign w_wb_dat    = (w_op == OP_LW) ? r_mdr : r_alu;

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_R: begin
                case (w_funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_legal = 1'b1;
                    default:                               w_legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: w_legal = 1'b1;
            default:                             w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_res = r_a + r_imm;
        if (w_op == OP_R) begin
            case (w_funct)
                FN_SUB:  w_alu_res = r_a - r_b;
                FN_AND:  w_alu_res = r_a & r_b;
                FN_OR:   w_alu_res = r_a | r_b;
                FN_SLT:  w_alu_res = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
                default: w_alu_res = r_a + r_b;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC[ADDR_W-1:0];
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_instret <= '0;
            r_trap    <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fire) begin
                        r_ir    <= i_mem_rdata;
                        r_pc    <= r_pc + ADDR_W'(4);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                    if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (!w_legal) begin
                        r_state <= S_HALT;
                        r_trap  <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        OP_R, OP_ADDI: begin
                            r_alu   <= w_alu_res;
                            r_state <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            r_alu   <= w_alu_res;
                            r_state <= S_MEM;
                        end
                        OP_BEQ: begin
                            if (r_a == r_b) r_pc <= w_br_target;
                            r_instret <= r_instret + 32'd1;
                            r_state   <= S_FETCH;
                        end
                        default: begin
                            r_pc      <= w_j_target;
                            r_instret <= r_instret + 32'd1;
                            r_state   <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (w_fire) begin
                        if (w_op == OP_SW) begin
                            r_instret <= r_instret + 32'd1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_mdr   <= i_mem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_wb_dst != 5'd0) r_regs[w_wb_dst] <= w_wb_dat;
                    r_instret <= r_instret + 32'd1;
                    r_state   <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end
endmodule
